// File: rtl/serial_pkg.sv
// Shared constants and state encodings for the serial work-load link.
// The receive side uses the same packet lengths and bit-period derivation,
// so both ends agree on framing by construction.
package serial_pkg;

  localparam int KRAMBLE_BYTES    = 44;
  localparam int ICARUS_BYTES     = 64;
  localparam int ICARUS_PAD_BYTES = 20;
  localparam int MIDSTATE_BYTES   = 32;
  localparam int PACKET_BITS      = 352;

  // Bit-level states of the byte transmitter.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_GAP
  } tx_state_e;

  // Packet-level states of the work transmitter.
  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_SEND,
    PKT_WAIT,
    PKT_FIN
  } pkt_state_e;

  // One bit lasts 2*SPEED_MHZ clocks, identical to the receiver.
  function automatic int clk_per_bit(input int speed_mhz);
    return 2 * speed_mhz;
  endfunction

  function automatic int packet_bytes(input int icarus);
    return (icarus != 0) ? ICARUS_BYTES : KRAMBLE_BYTES;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter with a configurable idle gap after the stop bit.
// Handshake: a byte transfers on a clock edge where start=1 and busy=0.
// busy drops during the final clock of a frame (last stop or gap clock), so
// a byte offered then starts on the very next clock with no idle cycles.
module uart_tx_byte
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = 100,
  parameter int GAP_BITS    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       tx
);

  localparam logic [7:0] BIT_LAST = 8'(CLK_PER_BIT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

  tx_state_e  state_q;
  logic [7:0] cnt_q;
  logic [3:0] idx_q;
  logic [7:0] shreg_q;
  logic       tx_q;

  logic bit_end;
  logic frame_end;
  logic take;

  // Frame ends on the last clock of the stop bit, or of the last gap bit.
  always_comb begin
    bit_end   = (cnt_q == BIT_LAST);
    frame_end = bit_end &&
                (((state_q == TX_STOP) && (GAP_BITS == 0)) ||
                 ((state_q == TX_GAP) && (idx_q == GAP_LAST)));
    busy      = !((state_q == TX_IDLE) || frame_end);
    take      = start && !busy;
  end

  assign tx = tx_q;

  // Bit sequencer: start, 8 data bits LSB first, stop, then the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else if (take) begin
      state_q <= TX_START;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= data;
      tx_q    <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
        end
        TX_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[7:1]};
            state_q <= TX_DATA;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == 4'd7) begin
              idx_q   <= '0;
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              idx_q   <= idx_q + 4'd1;
              tx_q    <= shreg_q[0];
              shreg_q <= {1'b0, shreg_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= (GAP_BITS == 0) ? TX_IDLE : TX_GAP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        TX_GAP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == GAP_LAST) begin
              idx_q   <= '0;
              state_q <= TX_IDLE;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_work_transmit.sv
// Sends one midstate+data2 work packet as a UART byte stream, MSB byte first.
// The packet is captured into a shift buffer on accept; icarus padding bytes
// are produced from the byte counter and never occupy buffer space.
module serial_work_transmit
  import serial_pkg::*;
#(
  parameter int SPEED_MHZ = 50,
  parameter int ICARUS    = 0,
  parameter int GAP_BITS  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] midstate,
  input  logic [95:0]  data2,
  input  logic         load,
  output logic         busy,
  output logic         done,
  output logic         TxD
);

  localparam int         CLK_PER_BIT = clk_per_bit(SPEED_MHZ);
  localparam int         N_BYTES     = packet_bytes(ICARUS);
  localparam logic [6:0] LAST_BYTE   = 7'(N_BYTES - 1);
  localparam logic [6:0] PAD_FIRST   = 7'(MIDSTATE_BYTES);
  localparam logic [6:0] PAD_END     = 7'(MIDSTATE_BYTES + ICARUS_PAD_BYTES);

  pkt_state_e             state_q;
  logic [PACKET_BITS-1:0] buf_q;
  logic [6:0]             byte_cnt_q;
  logic                   busy_q;
  logic                   done_q;

  logic       is_pad;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_take;

  // Byte offered to the transmitter: zero padding or the buffer's top byte.
  always_comb begin
    is_pad   = (ICARUS != 0) && (byte_cnt_q >= PAD_FIRST) && (byte_cnt_q < PAD_END);
    tx_data  = is_pad ? 8'h00 : buf_q[PACKET_BITS-1 -: 8];
    tx_start = (state_q == PKT_SEND);
    tx_take  = tx_start && !tx_busy;
  end

  // Packet sequencer. busy_q stays high through the done cycle and clears
  // one cycle later, so a load coinciding with done is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PKT_IDLE;
      buf_q      <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        PKT_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (load && !busy_q) begin
            buf_q      <= {midstate, data2};
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= PKT_SEND;
          end
        end
        PKT_SEND: begin
          if (tx_take) begin
            if (!is_pad) begin
              buf_q <= {buf_q[PACKET_BITS-9:0], 8'h00};
            end
            if (byte_cnt_q == LAST_BYTE) begin
              state_q <= PKT_WAIT;
            end else begin
              byte_cnt_q <= byte_cnt_q + 7'd1;
            end
          end
        end
        PKT_WAIT: begin
          if (!tx_busy) begin
            state_q <= PKT_FIN;
          end
        end
        PKT_FIN: begin
          done_q  <= 1'b1;
          state_q <= PKT_IDLE;
        end
        default: begin
          state_q <= PKT_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_PER_BIT(CLK_PER_BIT),
    .GAP_BITS   (GAP_BITS)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .data (tx_data),
    .start(tx_start),
    .busy (tx_busy),
    .tx   (TxD)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_work_transmit.sv
// Directed bench for serial_work_transmit: three instances (kramble gap 2,
// icarus gap 2, kramble gap 0) at 8 clocks per bit, decoded by a UART
// receiver task and compared against byte values derived from the inputs.
module tb_serial_work_transmit;

  localparam int SPEED = 4;
  localparam int CPB   = 8;

  localparam logic [255:0] MID_A  = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
  localparam logic [95:0]  DATA_A = 96'hA5A5_5A5A_1234_5678_9ABC_DEF0;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [255:0] midstate;
  logic [95:0]  data2;
  logic load0, load1, load2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;
  logic txd0, txd1, txd2;

  serial_work_transmit #(.SPEED_MHZ(SPEED), .ICARUS(0), .GAP_BITS(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .midstate(midstate), .data2(data2),
    .load(load0), .busy(busy0), .done(done0), .TxD(txd0));
  serial_work_transmit #(.SPEED_MHZ(SPEED), .ICARUS(1), .GAP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .midstate(midstate), .data2(data2),
    .load(load1), .busy(busy1), .done(done1), .TxD(txd1));
  serial_work_transmit #(.SPEED_MHZ(SPEED), .ICARUS(0), .GAP_BITS(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .midstate(midstate), .data2(data2),
    .load(load2), .busy(busy2), .done(done2), .TxD(txd2));

  // cycle counter and done monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_n [3] = '{0, 0, 0};
  int done_at [3] = '{0, 0, 0};
  always @(posedge clk) begin
    if (done0 === 1'b1) begin done_n[0] = done_n[0] + 1; done_at[0] = cyc; end
    if (done1 === 1'b1) begin done_n[1] = done_n[1] + 1; done_at[1] = cyc; end
    if (done2 === 1'b1) begin done_n[2] = done_n[2] + 1; done_at[2] = cyc; end
  end

  // scoreboard state
  int total = 0;
  int bad = 0;
  int load_cyc = 0;
  int done_base = 0;
  logic [7:0] rx_b [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [255:0] m, input logic [95:0] d,
                                          input int icarus, input int i);
    if (i < 32) return m[255 - 8*i -: 8];
    if (icarus != 0) begin
      if (i < 52) return 8'h00;
      return d[95 - 8*(i-52) -: 8];
    end
    return d[95 - 8*(i-32) -: 8];
  endfunction

  function automatic logic txsel(input int d);
    case (d)
      0: return txd0;
      1: return txd1;
      default: return txd2;
    endcase
  endfunction

  function automatic logic busysel(input int d);
    case (d)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic set_load(input int d, input logic v);
    case (d)
      0: load0 = v;
      1: load1 = v;
      default: load2 = v;
    endcase
  endtask

  // driver: one-cycle load pulse, then latency checks; returns at the
  // falling clock edge inside the first clock of the start bit
  task automatic do_load(input int d);
    done_base = done_n[d];
    set_load(d, 1'b1);
    @(negedge clk);
    load_cyc = cyc;
    set_load(d, 1'b0);
    chk($sformatf("dut%0d busy after load", d), 32'(busysel(d)), 32'd1);
    chk($sformatf("dut%0d txd high at +1", d), 32'(txsel(d)), 32'd1);
    @(negedge clk);
    chk($sformatf("dut%0d txd start at +2", d), 32'(txsel(d)), 32'd0);
  endtask

  // UART decoder: samples each bit in its middle, checks every byte
  task automatic rx_packet(input int d, input int n, input int gap,
                           input logic [255:0] m, input logic [95:0] dd, input int icarus);
    int fe;
    bit found;
    logic [7:0] b;
    fe = 0;
    b = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        found = 1'b0;
        for (int w = 0; w < CPB*(gap+2); w++) begin
          @(negedge clk);
          if (txsel(d) === 1'b0) begin
            found = 1'b1;
            break;
          end
        end
        chk($sformatf("dut%0d start bit of byte %0d", d, i), 32'(found), 32'd1);
        if (!found) return;
      end
      repeat (CPB/2) @(negedge clk);
      if (txsel(d) !== 1'b0) fe++;
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge clk);
        b[j] = txsel(d);
      end
      repeat (CPB) @(negedge clk);
      if (txsel(d) !== 1'b1) fe++;
      rx_b[i] = b;
      chk($sformatf("dut%0d byte%0d", d, i), 32'(b), 32'(exp_byte(m, dd, icarus, i)));
    end
    chk($sformatf("dut%0d framing errors", d), 32'(fe), 32'd0);
  endtask

  task automatic wait_done(input int d, input int n, input int gap);
    bit seen;
    seen = 1'b0;
    for (int w = 0; w < 400; w++) begin
      if (done_n[d] > done_base) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("dut%0d done seen", d), 32'(seen), 32'd1);
    chk($sformatf("dut%0d done time", d), 32'(done_at[d] - load_cyc), 32'(n*(10+gap)*CPB + 2));
    repeat (4) @(negedge clk);
    chk($sformatf("dut%0d done once", d), 32'(done_n[d] - done_base), 32'd1);
    chk($sformatf("dut%0d busy clear", d), 32'(busysel(d)), 32'd0);
    chk($sformatf("dut%0d txd idle", d), 32'(txsel(d)), 32'd1);
  endtask

  initial begin
    int viol;
    int t_first;
    int base_first;
    bit found;

    rst_n = 1'b0;
    load0 = 1'b0;
    load1 = 1'b0;
    load2 = 1'b0;
    midstate = MID_A;
    data2 = DATA_A;

    // reset values
    repeat (3) @(negedge clk);
    chk("reset txd", 32'({txd0, txd1, txd2}), 32'h7);
    chk("reset busy", 32'({busy0, busy1, busy2}), 32'h0);
    chk("reset done", 32'({done0, done1, done2}), 32'h0);
    rst_n = 1'b1;

    // idle line after reset
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if ({txd0, txd1, txd2} !== 3'b111 || {busy0, busy1, busy2} !== 3'b000 ||
          {done0, done1, done2} !== 3'b000) viol++;
    end
    chk("idle after reset", 32'(viol), 32'd0);

    // kramble packet; loads during the packet with changed inputs are ignored
    do_load(0);
    fork
      rx_packet(0, 44, 2, MID_A, DATA_A, 0);
      begin
        repeat (50) @(negedge clk);
        midstate = ~MID_A;
        data2 = ~DATA_A;
        load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        repeat (2000) @(negedge clk);
        load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
      end
    join
    chk("dut0 first byte", 32'(rx_b[0]), 32'h01);
    chk("dut0 last byte", 32'(rx_b[43]), 32'hF0);
    wait_done(0, 44, 2);
    midstate = MID_A;
    data2 = DATA_A;

    // icarus packet with zero padding
    do_load(1);
    rx_packet(1, 64, 2, MID_A, DATA_A, 1);
    chk("dut1 pad first", 32'(rx_b[32]), 32'h00);
    chk("dut1 pad last", 32'(rx_b[51]), 32'h00);
    chk("dut1 data2 first", 32'(rx_b[52]), 32'hA5);
    chk("dut1 last byte", 32'(rx_b[63]), 32'hF0);
    wait_done(1, 64, 2);

    // no gap; load on the done cycle is dropped, load one cycle later starts
    do_load(2);
    t_first = load_cyc;
    base_first = done_base;
    rx_packet(2, 44, 0, MID_A, DATA_A, 0);
    found = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (done2 === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("dut2 done pulse", 32'(found), 32'd1);
    chk("dut2 busy during done", 32'(busy2), 32'd1);
    midstate = ~MID_A;
    data2 = ~DATA_A;
    load2 = 1'b1;
    @(negedge clk);
    chk("dut2 load on done cycle ignored", 32'(busy2), 32'd0);
    chk("dut2 first done time", 32'(done_at[2] - t_first), 32'(44*10*CPB + 2));
    chk("dut2 first done once", 32'(done_n[2] - base_first), 32'd1);
    @(negedge clk);
    load_cyc = cyc;
    load2 = 1'b0;
    done_base = done_n[2];
    chk("dut2 busy after reload", 32'(busy2), 32'd1);
    chk("dut2 txd high at +1", 32'(txd2), 32'd1);
    @(negedge clk);
    chk("dut2 txd start at +2", 32'(txd2), 32'd0);
    rx_packet(2, 44, 0, ~MID_A, ~DATA_A, 0);
    chk("dut2 second packet first byte", 32'(rx_b[0]), 32'hFE);
    wait_done(2, 44, 0);
    midstate = MID_A;
    data2 = DATA_A;

    // asynchronous reset in the middle of byte 10 (data bit 0 of 8'hBA)
    do_load(0);
    repeat (10*12*CPB + 12) @(negedge clk);
    chk("dut0 busy before abort", 32'(busy0), 32'd1);
    chk("dut0 txd low before abort", 32'(txd0), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("dut0 txd forced high in reset", 32'(txd0), 32'd1);
    chk("dut0 busy cleared in reset", 32'(busy0), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("dut0 no done after abort", 32'(done_n[0] - done_base), 32'd0);
    chk("dut0 idle after abort", 32'({txd0, busy0}), 32'h2);

    // complete packet after the abort, with fresh data
    midstate = {MID_A[127:0], MID_A[255:128]};
    data2 = DATA_A ^ 96'h0000_0000_0000_0000_0000_00FF;
    do_load(0);
    rx_packet(0, 44, 2, {MID_A[127:0], MID_A[255:128]},
              DATA_A ^ 96'h0000_0000_0000_0000_0000_00FF, 0);
    chk("dut0 post-abort first byte", 32'(rx_b[0]), 32'h00);
    chk("dut0 post-abort last byte", 32'(rx_b[43]), 32'h0F);
    wait_done(0, 44, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
